// File: rtl/mul_pkg.sv
// ----------------------------------------------------------------------------
// mul_pkg
//   Shared definitions for the sequential RV32M multiply unit:
//     - opcode constants (MUL / MULH / MULHSU / MULHU)
//     - 3-bit FSM state encoding
//     - iteration count and a two's-complement helper
//   No ports (package).
// ----------------------------------------------------------------------------
package mul_pkg;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;
   localparam logic [1:0] OP_MULHU  = 2'b11;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] RUN    = 3'd1;
   localparam logic [2:0] NEG_LO = 3'd2;
   localparam logic [2:0] NEG_HI = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;

   localparam int ITERS = 32;

   // Two's-complement negation; 0x80000000 maps to itself, which read as
   // unsigned is exactly its magnitude.
   function automatic logic [31:0] negate32(input logic [31:0] x);
      return ~x + 32'd1;
   endfunction

endpackage

// File: rtl/seq_multiplier_adder.sv
// ----------------------------------------------------------------------------
// adder
//   32-bit ripple-carry adder shared by every arithmetic step of the
//   sequential multiplier.
//   Ports:
//     a, b  : 32-bit addends
//     cin   : carry in
//     sum   : 32-bit sum
//     cout  : carry out
// ----------------------------------------------------------------------------
module adder (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);

   logic [32:0] carry;

   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = cin;
      for (int i = 0; i < 32; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry[i];
         carry[i + 1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
      end
   end

   assign cout = carry[32];

endmodule

// File: rtl/seq_multiplier.sv
// ----------------------------------------------------------------------------
// seq_multiplier
//   Multi-cycle RV32M multiply unit (MUL, MULH, MULHSU, MULHU). Operands are
//   converted to magnitudes on accept, multiplied by 32 shift-add iterations
//   through a single shared adder, and the 64-bit product is negated in two
//   extra adder passes when exactly one effective operand was negative.
//
//   Optional feature (macro MUL_ZERO_BYPASS_EN): a zero operand skips the
//   iterations and goes straight to DONE with a zero product.
//
//   Ports:
//     clk        : rising-edge clock
//     rst        : asynchronous active-high reset
//     in_valid   : request valid
//     in_ready   : unit idle and able to accept
//     in_op      : 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//     in_a       : rs1 operand
//     in_b       : rs2 operand
//     out_valid  : result valid (held until out_ready)
//     out_ready  : consumer accepts result
//     out_result : MUL -> product[31:0], others -> product[63:32]
// ----------------------------------------------------------------------------
module seq_multiplier
   import mul_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result
);

   logic [2:0]       state;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH-1:0] mcand;
   logic [CNT_W-1:0] cnt;
   logic             neg;
   logic             sel_hi;
   logic             carry;

   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic             add_cin;
   logic [WIDTH-1:0] add_sum;
   logic             add_cout;

   logic             accept;
   logic             sa;
   logic             sb;
   logic             neg_a;
   logic             neg_b;
   logic             bypass;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid && in_ready;

   // MULH treats both operands as signed, MULHSU only rs1.
   assign sa    = (in_op == OP_MULH) || (in_op == OP_MULHSU);
   assign sb    = (in_op == OP_MULH);
   assign neg_a = sa & in_a[WIDTH-1];
   assign neg_b = sb & in_b[WIDTH-1];

`ifdef MUL_ZERO_BYPASS_EN
   assign bypass = (in_a == '0) || (in_b == '0);
`else
   assign bypass = 1'b0;
`endif

   // Single adder shared by iteration and by the two negation passes.
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      case (state)
         RUN: begin
            add_a = acc_hi;
            add_b = acc_lo[0] ? mcand : '0;
         end
         NEG_LO: begin
            add_a   = ~acc_lo;
            add_cin = 1'b1;
         end
         NEG_HI: begin
            add_a   = ~acc_hi;
            add_cin = carry;
         end
         default: ;
      endcase
   end

   adder u_adder (
      .a    (add_a),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         acc_hi     <= '0;
         acc_lo     <= '0;
         mcand      <= '0;
         cnt        <= '0;
         neg        <= 1'b0;
         sel_hi     <= 1'b0;
         carry      <= 1'b0;
         out_valid  <= 1'b0;
         out_result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  neg    <= neg_a ^ neg_b;
                  mcand  <= neg_a ? negate32(in_a) : in_a;
                  acc_lo <= bypass ? '0 : (neg_b ? negate32(in_b) : in_b);
                  acc_hi <= '0;
                  cnt    <= '0;
                  sel_hi <= (in_op != OP_MUL);
                  state  <= bypass ? DONE : RUN;
               end
            end
            RUN: begin
               // Shift the 65-bit {cout, sum, multiplier} window right by one.
               {acc_hi, acc_lo} <= {add_cout, add_sum, acc_lo[WIDTH-1:1]};
               cnt              <= cnt + 1'b1;
               if (cnt == CNT_W'(ITERS - 1)) begin
                  state <= neg ? NEG_LO : DONE;
               end
            end
            NEG_LO: begin
               acc_lo <= add_sum;
               carry  <= add_cout;
               state  <= NEG_HI;
            end
            NEG_HI: begin
               acc_hi <= add_sum;
               state  <= DONE;
            end
            DONE: begin
               // Result is latched once on entry and held while stalled.
               if (!out_valid) begin
                  out_valid  <= 1'b1;
                  out_result <= sel_hi ? acc_hi : acc_lo;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// ----------------------------------------------------------------------------
// tb_seq_multiplier
//   Self-checking bench for seq_multiplier. Expected results come from a
//   64-bit arithmetic reference of the RV32M multiply definitions.
// ----------------------------------------------------------------------------
module tb_seq_multiplier;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_op = 2'b00;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;

   int n_checks = 0;
   int n_fail   = 0;

   seq_multiplier #(.WIDTH(32), .CNT_W(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result)
   );

   always #5 clk = ~clk;

   // Reference: extend each operand according to the op, multiply exactly.
   function automatic logic [31:0] ref_mul(input logic [1:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [65:0] x;
      logic signed [65:0] y;
      logic signed [65:0] p;
      x = (op == 2'b01 || op == 2'b10) ? {{34{a[31]}}, a} : {34'b0, a};
      y = (op == 2'b01) ? {{34{b[31]}}, b} : {34'b0, b};
      p = x * y;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   function automatic int ref_lat(input logic [1:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      bit neg;
`ifdef MUL_ZERO_BYPASS_EN
      if (a == 0 || b == 0) return 1;
`endif
      neg = ((op == 2'b01 || op == 2'b10) && a[31]) ^ ((op == 2'b01) && b[31]);
      return neg ? 35 : 33;
   endfunction

   // Issue one operation (called #1 after a rising edge); report result,
   // latency (-1 on timeout), stall stability and in_ready behaviour.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int stall,
                         output logic [31:0] res, output int lat,
                         output bit stable, output bit ready_ok);
      in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a = $urandom; in_b = $urandom; in_op = 2'($urandom);
      lat = 0; ready_ok = 1'b1; stable = 1'b1;
      while (!out_valid && lat < 200) begin
         if (in_ready) ready_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) begin
         lat = -1;
         res = 'x;
         return;
      end
      res = out_result;
      repeat (stall) begin
         @(posedge clk); #1;
         if (!out_valid || out_result !== res || in_ready) stable = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      if (!in_ready || out_valid) ready_ok = 1'b0;
   endtask

   task automatic test_vector(input string name, input logic [1:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp, input int stall);
      logic [31:0] res;
      int lat;
      int exp_lat;
      bit stable, ready_ok;
      exp_lat = ref_lat(op, a, b);
      run_op(op, a, b, stall, res, lat, stable, ready_ok);
      n_checks++;
      if (res !== exp) begin
         n_fail++;
         $display("FAIL %s result: got %h expected %h", name, res, exp);
      end
      n_checks++;
      if (lat !== exp_lat) begin
         n_fail++;
         $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
      end
      n_checks++;
      if (stable !== 1'b1) begin
         n_fail++;
         $display("FAIL %s stall stability: got %0d expected 1", name, stable);
      end
      n_checks++;
      if (ready_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL %s in_ready sequencing: got %0d expected 1", name, ready_ok);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({in_ready, out_valid, out_result} !== {1'b1, 1'b0, 32'h0}) begin
         n_fail++;
         $display("FAIL reset state: got ready=%b valid=%b result=%h expected 1 0 00000000",
                  in_ready, out_valid, out_result);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      test_vector("mul_3x5", 2'b00, 32'd3, 32'd5, 32'h0000000F, 0);
      test_vector("mulh_min_x2", 2'b01, 32'h80000000, 32'd2, 32'hFFFFFFFF, 0);
      test_vector("mulhu_max", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
   endtask

   task automatic test_signed_corners();
      test_vector("mulh_m1_m1", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0);
      test_vector("mulhsu_m1_2", 2'b10, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 0);
      test_vector("mulh_min_min", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 0);
      test_vector("mul_neg_lo", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 0);
   endtask

   task automatic test_backpressure();
      test_vector("mul_7x6_stall", 2'b00, 32'd7, 32'd6, 32'h0000002A, 5);
   endtask

   task automatic test_reset_abort();
      in_op = 2'b00; in_a = 32'h1234; in_b = 32'h5678; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL reset_abort: got valid=%b ready=%b expected valid=0 ready=1",
                  out_valid, in_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      test_vector("mul_2x2_after_rst", 2'b00, 32'd2, 32'd2, 32'd4, 0);
   endtask

   task automatic test_zero_bypass();
      test_vector("mulhu_0x9", 2'b11, 32'd0, 32'd9, 32'd0, 0);
      test_vector("mulh_m5x0", 2'b01, 32'hFFFFFFFB, 32'd0, 32'd0, 1);
   endtask

   task automatic test_random();
      logic [1:0]  op;
      logic [31:0] a, b;
      for (int i = 0; i < 30; i++) begin
         op = 2'($urandom);
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 7) == 0) a = '0;
         if ($urandom_range(0, 7) == 0) b = '0;
         test_vector("random", op, a, b, ref_mul(op, a, b), $urandom_range(0, 3));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed_corners();
      test_backpressure();
      test_reset_abort();
      test_zero_bypass();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
